// File: rtl/cmos_nvram_io.sv
// rtl/cmos_nvram_io.sv - HPS upload/download responder for the 1024x4 Williams CMOS RAM
// Packs nibble pairs into bytes for hps_io and flags CPU writes as a pending save.
module cmos_nvram_io #(
    parameter int NV_INDEX = 4,
    parameter int CMOS_AW  = 10
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               ioctl_upload,
    input  logic               ioctl_download,
    input  logic [15:0]        ioctl_index,
    input  logic [24:0]        ioctl_addr,
    input  logic               ioctl_rd,
    input  logic               ioctl_wr,
    input  logic [7:0]         ioctl_dout,
    output logic [7:0]         ioctl_din,
    output logic               ioctl_wait,
    output logic [CMOS_AW-1:0] cmos_addr,
    output logic [3:0]         cmos_din,
    output logic               cmos_we,
    input  logic [3:0]         cmos_dout,
    input  logic               cpu_cmos_we,
    output logic               nvram_dirty,
    output logic               busy
);

    localparam int BYTES = 2 ** (CMOS_AW - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        RD_CAP,
        WR_LO,
        WR_HI
    } state_t;

    state_t     state;
    logic [3:0] lo_q;
    logic [3:0] hi_q;
    logic       dl_q;

    logic match;
    logic in_range;
    logic last_byte;
    logic dirty_clr;

    assign match     = (ioctl_index == 16'(NV_INDEX));
    assign in_range  = (ioctl_addr < 25'(BYTES));
    // cmos_addr still holds the odd nibble of the byte being captured in RD_CAP
    assign last_byte = &cmos_addr[CMOS_AW-1:1];
    assign dirty_clr = ((state == RD_CAP) && last_byte) ||
                       (dl_q && !ioctl_download && match);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ioctl_din   <= 8'h00;
            ioctl_wait  <= 1'b0;
            cmos_addr   <= '0;
            cmos_din    <= 4'h0;
            cmos_we     <= 1'b0;
            nvram_dirty <= 1'b0;
            lo_q        <= 4'h0;
            hi_q        <= 4'h0;
            dl_q        <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            case (state)
                IDLE: begin
                    cmos_we <= 1'b0;
                    if (ioctl_rd && ioctl_upload && match) begin
                        if (in_range) begin
                            cmos_addr  <= {ioctl_addr[CMOS_AW-2:0], 1'b0};
                            ioctl_wait <= 1'b1;
                            state      <= RD_LO;
                        end else begin
                            ioctl_din <= 8'hFF;
                        end
                    end else if (ioctl_wr && ioctl_download && match && in_range) begin
                        cmos_addr  <= {ioctl_addr[CMOS_AW-2:0], 1'b0};
                        cmos_din   <= ioctl_dout[3:0];
                        hi_q       <= ioctl_dout[7:4];
                        cmos_we    <= 1'b1;
                        ioctl_wait <= 1'b1;
                        state      <= WR_LO;
                    end
                end
                RD_LO: begin
                    cmos_addr[0] <= 1'b1;
                    state        <= RD_HI;
                end
                RD_HI: begin
                    lo_q  <= cmos_dout;
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    ioctl_din  <= {cmos_dout, lo_q};
                    ioctl_wait <= 1'b0;
                    state      <= IDLE;
                end
                WR_LO: begin
                    cmos_addr[0] <= 1'b1;
                    cmos_din     <= hi_q;
                    state        <= WR_HI;
                end
                WR_HI: begin
                    cmos_we    <= 1'b0;
                    ioctl_wait <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // a CPU write in the same cycle as a clear keeps the image marked dirty
            if (cpu_cmos_we) begin
                nvram_dirty <= 1'b1;
            end else if (dirty_clr) begin
                nvram_dirty <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cmos_nvram_io.sv
// tb/tb_cmos_nvram_io.sv - self-checking bench for cmos_nvram_io
// Table vectors, random ops against a nibble-array model, and hand-written corner cases.
module tb_cmos_nvram_io;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_upload = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [15:0] ioctl_index = 16'd0;
    logic [24:0] ioctl_addr = 25'd0;
    logic        ioctl_rd = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_dout = 8'h00;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic [9:0]  cmos_addr;
    logic [3:0]  cmos_din;
    logic        cmos_we;
    logic [3:0]  cmos_dout = 4'h0;
    logic        cpu_cmos_we = 1'b0;
    logic        nvram_dirty;
    logic        busy;

    cmos_nvram_io #(.NV_INDEX(4), .CMOS_AW(10)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_upload(ioctl_upload), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_rd(ioctl_rd), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
        .cmos_addr(cmos_addr), .cmos_din(cmos_din), .cmos_we(cmos_we),
        .cmos_dout(cmos_dout), .cpu_cmos_we(cpu_cmos_we),
        .nvram_dirty(nvram_dirty), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    // registered CMOS RAM seen by port B
    logic [3:0] mem [0:1023];
    logic [3:0] ref_nib [0:1023];
    logic       init_go = 1'b0;

    always @(posedge clk_sys) begin
        if (init_go) begin
            for (int i = 0; i < 1024; i++) mem[i] <= ref_nib[i];
        end else begin
            if (cmos_we) mem[cmos_addr] <= cmos_din;
            cmos_dout <= mem[cmos_addr];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input int n);
        return {ref_nib[2*n+1], ref_nib[2*n]};
    endfunction

    task automatic do_read(input logic [15:0] idx, input logic [24:0] addr, input bit sess,
                           output logic [7:0] din, output int wc, output int wec);
        @(negedge clk_sys);
        ioctl_index = idx; ioctl_addr = addr; ioctl_upload = sess; ioctl_rd = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_rd = 1'b0; wc = 0; wec = 0;
        for (int i = 0; i < 10 && ioctl_wait; i++) begin
            wc++;
            if (cmos_we) wec++;
            @(posedge clk_sys); #1;
        end
        if (cmos_we) wec++;
        din = ioctl_din;
        ioctl_upload = 1'b0;
        @(posedge clk_sys); #1;
    endtask

    task automatic do_write(input logic [15:0] idx, input logic [24:0] addr, input bit sess,
                            input logic [7:0] data, output int wc, output int wec,
                            output logic [9:0] a1, output logic [3:0] d1,
                            output logic [9:0] a2, output logic [3:0] d2);
        @(negedge clk_sys);
        ioctl_index = idx; ioctl_addr = addr; ioctl_download = sess;
        ioctl_dout = data; ioctl_wr = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0; wc = 0; wec = 0;
        a1 = '0; d1 = '0; a2 = '0; d2 = '0;
        for (int i = 0; i < 10 && (ioctl_wait || cmos_we); i++) begin
            if (ioctl_wait) wc++;
            if (cmos_we) begin
                if (wec == 0) begin a1 = cmos_addr; d1 = cmos_din; end
                else if (wec == 1) begin a2 = cmos_addr; d2 = cmos_din; end
                wec++;
            end
            @(posedge clk_sys); #1;
        end
        ioctl_download = 1'b0;
        @(posedge clk_sys); #1;
    endtask

    task automatic model_write(input logic [15:0] idx, input logic [24:0] addr, input bit sess,
                               input logic [7:0] data);
        if (sess && idx == 16'd4 && addr < 25'd512) begin
            ref_nib[2*addr]   = data[3:0];
            ref_nib[2*addr+1] = data[7:4];
        end
    endtask

    task automatic cpu_pulse();
        @(negedge clk_sys); cpu_cmos_we = 1'b1;
        @(negedge clk_sys); cpu_cmos_we = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        bit          sess;
        logic [15:0] idx;
        logic [24:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp_din;
        int          exp_wait;
        int          exp_we;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [7:0]  din, din_hold;
        int          wc, wec;
        logic [9:0]  a1, a2;
        logic [3:0]  d1, d2;
        bit          exp_dirty;
        logic [15:0] idx;
        logic [24:0] addr;
        logic [7:0]  data;
        bit          sess;
        bit          is_wr;

        tbl[0]  = '{0, 1, 16'd4, 25'd0,         8'h00, 8'hA3, 3, 0};
        tbl[1]  = '{1, 1, 16'd4, 25'd5,         8'h7C, 8'hA3, 2, 2};
        tbl[2]  = '{0, 1, 16'd4, 25'd5,         8'h00, 8'h7C, 3, 0};
        tbl[3]  = '{0, 1, 16'd4, 25'd512,       8'h00, 8'hFF, 0, 0};
        tbl[4]  = '{0, 1, 16'd0, 25'd0,         8'h00, 8'hFF, 0, 0};
        tbl[5]  = '{0, 0, 16'd4, 25'd0,         8'h00, 8'hFF, 0, 0};
        tbl[6]  = '{1, 1, 16'd4, 25'd700,       8'h11, 8'hFF, 0, 0};
        tbl[7]  = '{1, 1, 16'd3, 25'd6,         8'h22, 8'hFF, 0, 0};
        tbl[8]  = '{1, 0, 16'd4, 25'd6,         8'h33, 8'hFF, 0, 0};
        tbl[9]  = '{1, 1, 16'd4, 25'd6,         8'h5A, 8'hFF, 2, 2};
        tbl[10] = '{0, 1, 16'd4, 25'd6,         8'h00, 8'h5A, 3, 0};
        tbl[11] = '{0, 1, 16'd4, 25'h1000006,   8'h00, 8'hFF, 0, 0};
        tbl[12] = '{1, 1, 16'd4, 25'd511,       8'h96, 8'hFF, 2, 2};
        tbl[13] = '{0, 1, 16'd4, 25'd511,       8'h00, 8'h96, 3, 0};

        for (int i = 0; i < 1024; i++) ref_nib[i] = 4'($urandom_range(0, 15));
        ref_nib[0] = 4'h3; ref_nib[1] = 4'hA;
        ref_nib[40] = 4'h1; ref_nib[41] = 4'h2;

        @(negedge clk_sys); init_go = 1'b1;
        @(negedge clk_sys); init_go = 1'b0;
        @(negedge clk_sys);
        chk("rst_din", {24'd0, ioctl_din}, 32'h00);
        chk("rst_wait", {31'd0, ioctl_wait}, 32'd0);
        chk("rst_addr", {22'd0, cmos_addr}, 32'd0);
        chk("rst_cdin", {28'd0, cmos_din}, 32'd0);
        chk("rst_we", {31'd0, cmos_we}, 32'd0);
        chk("rst_dirty", {31'd0, nvram_dirty}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].wr) begin
                do_write(tbl[i].idx, tbl[i].addr, tbl[i].sess, tbl[i].data, wc, wec, a1, d1, a2, d2);
                model_write(tbl[i].idx, tbl[i].addr, tbl[i].sess, tbl[i].data);
            end else begin
                do_read(tbl[i].idx, tbl[i].addr, tbl[i].sess, din, wc, wec);
            end
            chk($sformatf("tbl%0d_din", i), {24'd0, ioctl_din}, {24'd0, tbl[i].exp_din});
            chk($sformatf("tbl%0d_wait", i), wc, tbl[i].exp_wait);
            chk($sformatf("tbl%0d_we", i), wec, tbl[i].exp_we);
        end
        din_hold = 8'h96;

        do_write(16'd4, 25'd5, 1'b1, 8'h7C, wc, wec, a1, d1, a2, d2);
        model_write(16'd4, 25'd5, 1'b1, 8'h7C);
        chk("wr5_wait", wc, 2);
        chk("wr5_we", wec, 2);
        chk("wr5_a1", {22'd0, a1}, 32'd10);
        chk("wr5_d1", {28'd0, d1}, 32'hC);
        chk("wr5_a2", {22'd0, a2}, 32'd11);
        chk("wr5_d2", {28'd0, d2}, 32'h7);

        exp_dirty = nvram_dirty === 1'b1 ? 1'b1 : 1'b0;
        chk("pre_rand_dirty", {31'd0, nvram_dirty}, 32'd0);
        exp_dirty = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                cpu_pulse();
                exp_dirty = 1'b1;
            end
            is_wr = $urandom_range(0, 1) == 1;
            idx   = ($urandom_range(0, 7) == 0) ? 16'd5 : 16'd4;
            sess  = $urandom_range(0, 9) != 0;
            addr  = ($urandom_range(0, 9) == 0) ? 25'd511 : 25'($urandom_range(0, 600));
            data  = 8'($urandom_range(0, 255));
            if (is_wr) begin
                do_write(idx, addr, sess, data, wc, wec, a1, d1, a2, d2);
                if (sess && idx == 16'd4) begin
                    exp_dirty = 1'b0;
                    chk($sformatf("rnd%0d_wr_wait", n), wc, addr < 512 ? 2 : 0);
                end else begin
                    chk($sformatf("rnd%0d_wr_wait", n), wc, 0);
                end
                model_write(idx, addr, sess, data);
            end else begin
                do_read(idx, addr, sess, din, wc, wec);
                if (sess && idx == 16'd4) begin
                    if (addr < 512) begin
                        din_hold = ref_byte(int'(addr));
                        if (addr == 511) exp_dirty = 1'b0;
                    end else begin
                        din_hold = 8'hFF;
                    end
                end
                chk($sformatf("rnd%0d_rd_wait", n), wc,
                    (sess && idx == 16'd4 && addr < 512) ? 3 : 0);
            end
            chk($sformatf("rnd%0d_din", n), {24'd0, ioctl_din}, {24'd0, din_hold});
            chk($sformatf("rnd%0d_dirty", n), {31'd0, nvram_dirty}, {31'd0, exp_dirty});
        end

        cpu_pulse();
        #1;
        chk("cpu_dirty", {31'd0, nvram_dirty}, 32'd1);

        for (int b = 0; b < 512; b++) begin
            do_read(16'd4, 25'(b), 1'b1, din, wc, wec);
            chk($sformatf("full%0d_din", b), {24'd0, din}, {24'd0, ref_byte(b)});
            if (b == 510) chk("full510_dirty", {31'd0, nvram_dirty}, 32'd1);
        end
        chk("full511_dirty", {31'd0, nvram_dirty}, 32'd0);

        @(negedge clk_sys);
        ioctl_index = 16'd4; ioctl_addr = 25'd511; ioctl_upload = 1'b1; ioctl_rd = 1'b1;
        @(posedge clk_sys); #1; ioctl_rd = 1'b0;
        @(posedge clk_sys);
        @(posedge clk_sys); #1; cpu_cmos_we = 1'b1;
        @(posedge clk_sys); #1; cpu_cmos_we = 1'b0;
        chk("coinc_wait", {31'd0, ioctl_wait}, 32'd0);
        chk("coinc_din", {24'd0, ioctl_din}, {24'd0, ref_byte(511)});
        chk("coinc_dirty", {31'd0, nvram_dirty}, 32'd1);
        ioctl_upload = 1'b0;

        @(negedge clk_sys);
        ioctl_index = 16'd4; ioctl_addr = 25'd3; ioctl_upload = 1'b1; ioctl_rd = 1'b1;
        @(posedge clk_sys); #1; ioctl_addr = 25'd7;
        @(posedge clk_sys); #1; ioctl_rd = 1'b0;
        chk("busy_mid", {31'd0, busy}, 32'd1);
        @(posedge clk_sys);
        @(posedge clk_sys); #1;
        chk("busy2_wait", {31'd0, ioctl_wait}, 32'd0);
        chk("busy2_din", {24'd0, ioctl_din}, {24'd0, ref_byte(3)});
        chk("busy2_idle", {31'd0, busy}, 32'd0);
        @(posedge clk_sys); #1;
        chk("busy2_nowait", {31'd0, ioctl_wait}, 32'd0);
        ioctl_upload = 1'b0;

        @(negedge clk_sys);
        ioctl_index = 16'd4; ioctl_addr = 25'd20; ioctl_download = 1'b1;
        ioctl_dout = 8'hFF; ioctl_wr = 1'b1;
        @(posedge clk_sys); #1; ioctl_wr = 1'b0;
        chk("wrlo_we", {31'd0, cmos_we}, 32'd1);
        reset = 1'b1;
        @(posedge clk_sys); #1;
        chk("rstmid_we", {31'd0, cmos_we}, 32'd0);
        chk("rstmid_wait", {31'd0, ioctl_wait}, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        ioctl_download = 1'b0;
        @(negedge clk_sys); reset = 1'b0;
        @(posedge clk_sys); @(posedge clk_sys); #1;
        chk("rstmid_odd", {28'd0, mem[41]}, {28'd0, ref_nib[41]});
        chk("rstmid_we_after", {31'd0, cmos_we}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
